xpb_table_gen: RTL and testbench
================================

Name: xpb_table_gen

Overview:
- Runtime-programmable successor to the fixed per-segment XPB constant tables used by the modular-squaring reduction.
- On a start pulse, latches a modulus N and a bit position SHIFT, then computes base = 2^SHIFT mod N.
- Fills an internal table with entry[i] = i*base mod N for i = 0..2^IDX_W-1.
- Serves NUM_RD independent registered lookups, so one instance replaces a family of hard-coded tables and can be reloaded when the modulus changes.

Parameters:
- WIDTH, 1024, modulus and entry width in bits.
- IDX_W, 5, lookup index width; table depth is 2^IDX_W.
- SHIFT_W, 11, width of the shift_in port.
- NUM_RD, 2, number of independent read ports.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; latches mod_in and shift_in and begins a build.
- mod_in  in  WIDTH  modulus N.
- shift_in  in  SHIFT_W  bit position SHIFT.
- busy  out  1  build in progress.
- ready  out  1  table valid for reads.
- done  out  1  one-cycle pulse when a build completes.
- err  out  1  last start had N==0; sticky until the next accepted start.
- rd_en  in  NUM_RD  per-port read request.
- rd_idx  in  NUM_RD*IDX_W  flattened indices; port p uses bits [p*IDX_W +: IDX_W].
- rd_valid  out  NUM_RD  per-port data valid.
- rd_data  out  NUM_RD*WIDTH  flattened read data; same packing as rd_idx.

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, FSM to IDLE, all table entries 0. Reset mid-build aborts the build; no done pulse is produced.
- FSM states: IDLE, INIT, BASE, FILL, READY.
- IDLE/READY + start with mod_in==0:
  - err=1, ready=0; FSM goes to IDLE.
  - No build is performed; the table is left untouched.
- IDLE/READY + start with mod_in!=0:
  - Latch N and SHIFT; err=0, ready=0, busy=1 from the next cycle; go to INIT.
- start while busy is ignored; latched values are unchanged.
- INIT, 1 cycle:
  - r = (N==1) ? 0 : 1.
  - entry[0] = 0.
  - Remaining count = SHIFT.
  - Next state is BASE, or FILL directly if SHIFT==0.
- BASE, SHIFT cycles; each cycle:
  - t = 2r, computed in WIDTH+1 bits.
  - r = (t >= N) ? t-N : t.
  - After the last cycle, base = r; go to FILL.
- FILL, 2^IDX_W-1 cycles; cycle k (k = 1..2^IDX_W-1):
  - t = entry[k-1] + base, computed in WIDTH+1 bits.
  - entry[k] = (t >= N) ? t-N : t.
- After the last FILL write, the next cycle is READY: ready=1, busy=0, done=1 for exactly that cycle.
- Build latency: with start sampled at edge 0, done is high in the cycle beginning at edge SHIFT + 2^IDX_W + 1.
- Arithmetic rules:
  - Every intermediate value stays < N by construction.
  - Exactly one compare/subtract per cycle; no division.
  - N above 2^(WIDTH-1) is legal; the WIDTH+1-bit intermediate covers 2N-1.
- Reads:
  - rd_en[p] sampled at edge e gives rd_valid[p]=1 and rd_data[p]=entry[rd_idx[p]] after edge e+1, i.e. 1-cycle latency.
  - Ports are fully independent; the same index on all ports is legal.
  - rd_en[p] while ready==0 gives rd_valid[p]=0 and rd_data[p]=0 on the next cycle.
  - rd_valid[p] is 0 in any cycle not following an accepted read; rd_data holds its last value.
- A start accepted in READY drops ready on the next cycle. Reads sampled in that same start cycle still return old-table data.
- Simultaneous start and rd_en in READY: the read is served from the old table; the rebuild proceeds.

Decomposition:
- Shared package xpb_pkg holds:
  - FSM state enum.
  - Function computing table depth from IDX_W.
  - WIDTH+1 intermediate-width constant.
- One sub-module, xpb_modadd: combinational (a+b) mod N with a,b < N, WIDTH+1-bit internal.
  - BASE calls it with a=b=r.
  - FILL calls it with a=entry[k-1], b=base.
  - A single shared instance is muxed by state.

Test Plan:
- Basic build: WIDTH=16, IDX_W=3, N=13, SHIFT=4. Start -> done pulse exactly 13 cycles after the start edge. Reading idx 0..7 returns 0,3,6,9,12,2,5,8.
- SHIFT=0 and N==1 cases:
  - WIDTH=16, IDX_W=3, N=13, SHIFT=0 -> done after 9 cycles; table 0,1,2,...,7.
  - N=1 -> all entries 0.
- Error path: start with mod_in=0 -> err=1, ready=0, no done pulse. A following start with N=13, SHIFT=4 clears err and rebuilds.
- Concurrent reads: NUM_RD=2, both ports read idx 5 every cycle in READY -> both return 2 each cycle. Reads before ready -> rd_valid=0, rd_data=0.
- Reset and rebuild:
  - Assert reset midway through BASE -> all outputs 0 immediately, no done pulse. Start afterwards -> correct table.
  - Start in READY with N=11, SHIFT=4 -> same-cycle read returns old value, ready drops next cycle, new table is 0,5,10,4,9,3,8,2.
- Full size: WIDTH=1024, IDX_W=5, SHIFT=850, random odd 1024-bit N -> all 32 entries match a software model of i*pow(2,850,N) mod N. done arrives at cycle 883.

Source files
------------

// File: rtl/xpb_pkg.sv
// Shared types and helpers for the programmable XPB table generator.
// Holds the FSM state encoding, table-depth helper and intermediate-width constants.
package xpb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_BASE,
        ST_FILL,
        ST_READY
    } xpb_state_t;

    localparam int XPB_WIDTH = 1024;
    localparam int XPB_EXT_W = XPB_WIDTH + 1;

    function automatic int table_depth(input int idx_w);
        return 1 << idx_w;
    endfunction

    // One extra bit so that a+b with a,b < N never overflows before reduction.
    function automatic int ext_width(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/xpb_modadd.sv
// Combinational modular adder: (a + b) mod n for a, b < n.
// A single compare/subtract suffices because the sum is at most 2n-2.
module xpb_modadd
    import xpb_pkg::*;
#(
    parameter int WIDTH = XPB_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] sum
);

    localparam int XW = ext_width(WIDTH);

    logic [XW-1:0] total;
    logic [XW-1:0] reduced;
    logic [XW-1:0] result;
    logic          unused_msb;

    always_comb begin
        total   = {1'b0, a} + {1'b0, b};
        reduced = total - {1'b0, n};
        result  = (total >= {1'b0, n}) ? reduced : total;
    end

    // The reduced result is always < n, so the top bit is always zero.
    assign sum        = result[WIDTH-1:0];
    assign unused_msb = result[XW-1];

endmodule

// File: rtl/xpb_table_gen.sv
// Runtime-programmable XPB table: builds entry[i] = i * (2^SHIFT mod N) mod N
// after a start pulse and serves NUM_RD independent registered lookups.
module xpb_table_gen
    import xpb_pkg::*;
#(
    parameter int WIDTH   = 1024,
    parameter int IDX_W   = 5,
    parameter int SHIFT_W = 11,
    parameter int NUM_RD  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [WIDTH-1:0]        mod_in,
    input  logic [SHIFT_W-1:0]      shift_in,
    output logic                    busy,
    output logic                    ready,
    output logic                    done,
    output logic                    err,
    input  logic [NUM_RD-1:0]       rd_en,
    input  logic [NUM_RD*IDX_W-1:0] rd_idx,
    output logic [NUM_RD-1:0]       rd_valid,
    output logic [NUM_RD*WIDTH-1:0] rd_data
);

    localparam int DEPTH = table_depth(IDX_W);

    xpb_state_t state;
    xpb_state_t next_state;

    logic [WIDTH-1:0]   n_q;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   acc_q;
    logic [SHIFT_W-1:0] cnt_q;
    logic [IDX_W-1:0]   k_q;
    logic [WIDTH-1:0]   table_q [DEPTH];

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_sum;
    logic             accept;
    logic             fill_last;
    logic             busy_d;
    logic             ready_d;
    logic             done_d;

    assign accept    = start && !busy && (state == ST_IDLE || state == ST_READY);
    assign fill_last = (k_q == {IDX_W{1'b1}});

    // BASE doubles r (a = b = r); FILL adds base (held in r_q) to the previous entry.
    assign add_a = (state == ST_FILL) ? acc_q : r_q;

    xpb_modadd #(.WIDTH(WIDTH)) u_modadd (
        .a   (add_a),
        .b   (r_q),
        .n   (n_q),
        .sum (add_sum)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE, ST_READY: if (accept) next_state = (mod_in == '0) ? ST_IDLE : ST_INIT;
            ST_INIT:           next_state = (cnt_q == '0) ? ST_FILL : ST_BASE;
            ST_BASE:           if (cnt_q == SHIFT_W'(1)) next_state = ST_FILL;
            ST_FILL:           if (fill_last) next_state = ST_READY;
            default:           next_state = ST_IDLE;
        endcase
    end

    // Status flags are registered, so ready/done appear one cycle after READY is entered.
    always_comb begin
        busy_d  = (next_state == ST_INIT) || (next_state == ST_BASE) ||
                  (next_state == ST_FILL) || (state == ST_FILL);
        ready_d = (state == ST_READY) && (next_state == ST_READY);
        done_d  = ready_d && !ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy  <= 1'b0;
            ready <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            busy  <= busy_d;
            ready <= ready_d;
            done  <= done_d;
            if (accept) err <= (mod_in == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_q   <= '0;
            r_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            k_q   <= '0;
            for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
        end else begin
            if (accept && mod_in != '0) begin
                n_q   <= mod_in;
                cnt_q <= shift_in;
            end
            unique case (state)
                ST_INIT: begin
                    r_q        <= (n_q == WIDTH'(1)) ? '0 : WIDTH'(1);
                    acc_q      <= '0;
                    table_q[0] <= '0;
                    k_q        <= IDX_W'(1);
                end
                ST_BASE: begin
                    r_q   <= add_sum;
                    cnt_q <= cnt_q - 1'b1;
                end
                ST_FILL: begin
                    table_q[k_q] <= add_sum;
                    acc_q        <= add_sum;
                    k_q          <= k_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Reads rejected while not ready return zero; idle ports hold their last data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= '0;
            rd_data  <= '0;
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                rd_valid[p] <= rd_en[p] && ready;
                if (rd_en[p]) begin
                    rd_data[p*WIDTH +: WIDTH] <= ready ? table_q[rd_idx[p*IDX_W +: IDX_W]] : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_xpb_table_gen.sv
// Scoreboard testbench for xpb_table_gen at WIDTH=16, IDX_W=3, NUM_RD=2.
// Reads push expected responses into a queue; a negedge monitor pops and compares them.
module tb_xpb_table_gen;

    localparam int W  = 16;
    localparam int IW = 3;
    localparam int SW = 11;
    localparam int NR = 2;
    localparam int D  = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [W-1:0]    mod_in = '0;
    logic [SW-1:0]   shift_in = '0;
    logic            busy, ready, done, err;
    logic [NR-1:0]   rd_en = '0;
    logic [NR*IW-1:0] rd_idx = '0;
    logic [NR-1:0]   rd_valid;
    logic [NR*W-1:0] rd_data;

    typedef struct {
        int         cyc;
        int         port;
        logic       valid;
        logic [W-1:0] data;
    } sb_item_t;

    sb_item_t     sb_q[$];
    sb_item_t     mon_it;
    logic [NR-1:0] mon_seen;
    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    logic [W-1:0] exp_tbl [D];
    bit           model_ready = 1'b0;

    xpb_table_gen #(.WIDTH(W), .IDX_W(IW), .SHIFT_W(SW), .NUM_RD(NR)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mod_in   (mod_in),
        .shift_in (shift_in),
        .busy     (busy),
        .ready    (ready),
        .done     (done),
        .err      (err),
        .rd_en    (rd_en),
        .rd_idx   (rd_idx),
        .rd_valid (rd_valid),
        .rd_data  (rd_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drives one sampling edge worth of inputs and returns #1 after that edge.
    task automatic apply_stimulus(input logic st, input logic [W-1:0] m, input logic [SW-1:0] s,
                                  input logic [NR-1:0] en, input int i0, input int i1);
        sb_item_t it;
        start    = st;
        mod_in   = m;
        shift_in = s;
        rd_en    = en;
        rd_idx   = {IW'(i1), IW'(i0)};
        for (int p = 0; p < NR; p++) begin
            if (en[p]) begin
                it.cyc   = cyc + 1;
                it.port  = p;
                it.valid = model_ready;
                it.data  = model_ready ? exp_tbl[(p == 0) ? i0 : i1] : '0;
                sb_q.push_back(it);
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        rd_en = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, '0, '0, '0, 0, 0);
    endtask

    task automatic start_build(input string name, input logic [W-1:0] n, input logic [SW-1:0] s,
                               input logic [NR-1:0] en, input int i0, input int i1, output int st);
        apply_stimulus(1'b1, n, s, en, i0, i1);
        st = cyc;
        model_ready = 1'b0;
        check_output({name, "_busy_after_start"}, busy, 1);
        check_output({name, "_ready_after_start"}, ready, 0);
        check_output({name, "_err_after_start"}, err, 0);
    endtask

    task automatic wait_done(input string name, input int st, input int lat);
        int got;
        got = -1;
        for (int i = 0; i < lat + 20 && got < 0; i++) begin
            idle(1);
            if (done) got = cyc - st;
        end
        check_output({name, "_done_latency"}, got, lat);
        check_output({name, "_ready_at_done"}, ready, 1);
        check_output({name, "_busy_at_done"}, busy, 0);
        idle(1);
        check_output({name, "_done_pulse_width"}, done, 0);
        model_ready = 1'b1;
    endtask

    task automatic read_all(input string name);
        for (int i = 0; i < D; i++) apply_stimulus(1'b0, '0, '0, 2'b11, i, D - 1 - i);
        idle(2);
        check_output({name, "_rd_data_hold"}, rd_data[W-1:0], exp_tbl[D-1]);
    endtask

    task automatic count_no_done(input string name, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            idle(1);
            if (done) seen++;
        end
        check_output({name, "_no_done"}, seen, 0);
    endtask

    function automatic logic [W-1:0] model_entry(input longint n, input int s, input int i);
        longint b;
        b = 1 % n;
        for (int k = 0; k < s; k++) b = (b * 2) % n;
        return W'((i * b) % n);
    endfunction

    task automatic load_hand(input int v0, input int v1, input int v2, input int v3,
                             input int v4, input int v5, input int v6, input int v7);
        exp_tbl[0] = W'(v0); exp_tbl[1] = W'(v1); exp_tbl[2] = W'(v2); exp_tbl[3] = W'(v3);
        exp_tbl[4] = W'(v4); exp_tbl[5] = W'(v5); exp_tbl[6] = W'(v6); exp_tbl[7] = W'(v7);
    endtask

    task automatic load_model(input longint n, input int s);
        for (int i = 0; i < D; i++) exp_tbl[i] = model_entry(n, s, i);
    endtask

    always @(negedge clk) begin
        mon_seen = '0;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            mon_it = sb_q.pop_front();
            if (mon_it.cyc < cyc) begin
                check_output("sb_stale_entry", cyc, mon_it.cyc);
            end else begin
                mon_seen[mon_it.port] = 1'b1;
                check_output($sformatf("rd_valid_p%0d", mon_it.port), rd_valid[mon_it.port], mon_it.valid);
                check_output($sformatf("rd_data_p%0d", mon_it.port), rd_data[mon_it.port*W +: W], mon_it.data);
            end
        end
        for (int p = 0; p < NR; p++)
            if (!reset && rd_valid[p] && !mon_seen[p]) check_output($sformatf("rd_valid_unexpected_p%0d", p), rd_valid[p], 0);
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int st;
        load_hand(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_output("reset_busy", busy, 0);
        check_output("reset_ready", ready, 0);
        check_output("reset_done", done, 0);
        check_output("reset_err", err, 0);
        check_output("reset_rd_valid", rd_valid, 0);
        check_output("reset_rd_data", rd_data, 0);
        reset = 1'b0;

        $display("[TB] reads before ready");
        apply_stimulus(1'b0, '0, '0, 2'b11, 5, 5);
        apply_stimulus(1'b0, '0, '0, 2'b01, 3, 0);

        $display("[TB] basic build N=13 SHIFT=4");
        start_build("basic", 16'd13, 11'd4, '0, 0, 0, st);
        wait_done("basic", st, 13);
        load_hand(0, 3, 6, 9, 12, 2, 5, 8);
        read_all("basic");
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, '0, '0, 2'b11, 5, 5);
        idle(1);

        $display("[TB] start in READY with same-cycle read, N=11 SHIFT=4");
        start_build("rebuild", 16'd11, 11'd4, 2'b11, 2, 5, st);
        wait_done("rebuild", st, 13);
        load_hand(0, 5, 10, 4, 9, 3, 8, 2);
        read_all("rebuild");

        $display("[TB] SHIFT=0 build");
        start_build("shift0", 16'd13, 11'd0, '0, 0, 0, st);
        wait_done("shift0", st, 9);
        load_hand(0, 1, 2, 3, 4, 5, 6, 7);
        read_all("shift0");

        $display("[TB] N=1 build");
        start_build("n_one", 16'd1, 11'd5, '0, 0, 0, st);
        wait_done("n_one", st, 14);
        load_hand(0, 0, 0, 0, 0, 0, 0, 0);
        read_all("n_one");

        $display("[TB] error path N=0");
        apply_stimulus(1'b1, 16'd0, 11'd4, '0, 0, 0);
        model_ready = 1'b0;
        check_output("err_set", err, 1);
        check_output("err_ready", ready, 0);
        check_output("err_busy", busy, 0);
        count_no_done("err", 20);
        check_output("err_sticky", err, 1);
        apply_stimulus(1'b0, '0, '0, 2'b11, 3, 6);
        start_build("after_err", 16'd13, 11'd4, '0, 0, 0, st);
        wait_done("after_err", st, 13);
        load_hand(0, 3, 6, 9, 12, 2, 5, 8);
        read_all("after_err");

        $display("[TB] reset midway through BASE");
        start_build("rst", 16'd13, 11'd20, '0, 0, 0, st);
        idle(5);
        reset = 1'b1;
        #1;
        check_output("rst_busy", busy, 0);
        check_output("rst_ready", ready, 0);
        check_output("rst_done", done, 0);
        check_output("rst_rd_data", rd_data, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_ready = 1'b0;
        count_no_done("rst", 40);
        check_output("rst_ready_after", ready, 0);
        start_build("post_rst", 16'd11, 11'd4, '0, 0, 0, st);
        wait_done("post_rst", st, 13);
        load_hand(0, 5, 10, 4, 9, 3, 8, 2);
        read_all("post_rst");

        $display("[TB] large modulus N=65521 SHIFT=100");
        start_build("big", 16'hFFF1, 11'd100, '0, 0, 0, st);
        wait_done("big", st, 109);
        load_model(64'hFFF1, 100);
        read_all("big");

        $display("[TB] start while busy is ignored, N=0x8001 SHIFT=37");
        start_build("busy_start", 16'h8001, 11'd37, '0, 0, 0, st);
        idle(5);
        apply_stimulus(1'b1, 16'd7, 11'd2, '0, 0, 0);
        wait_done("busy_start", st, 46);
        load_model(64'h8001, 37);
        read_all("busy_start");

        idle(2);
        check_output("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
